// File: rtl/alu_resp_if.sv
// Request/response bus for alu_resp: request handshake with operands, response
// handshake with the FIFO head fields and the running pop count.
interface alu_resp_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op_code;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_err;
  logic [7:0] txn_count;

  // Requester / response consumer side
  modport master (
    output req_valid, a, b, op_code, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, txn_count
  );

  // ALU side
  modport slave (
    input  req_valid, a, b, op_code, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, txn_count
  );
endinterface

// File: rtl/alu_resp.sv
// 8-bit ALU with a 2-entry in-order response FIFO. Results are computed
// combinationally from the request and stored on the accepting edge; the
// consumer pops the oldest result with a valid/ready handshake.
module alu_resp (
  input  logic       clk,
  input  logic       reset,
  alu_resp_if.slave  bus
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e     r_state;
  state_e     w_state_next;

  // Entries are packed as {err, carry, data}
  logic [9:0] w_result;
  logic [9:0] r_head;
  logic [9:0] r_tail;
  logic [7:0] r_txn_count;

  logic       w_req_ready;
  logic       w_rsp_valid;
  logic       w_push;
  logic       w_pop;

  logic [8:0] w_sum;
  logic [7:0] w_data;
  logic       w_carry;
  logic       w_err;

  // ALU: decode op_code into result data, carry/borrow and illegal-op flag
  always_comb begin
    w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    w_data  = 8'h00;
    w_carry = 1'b0;
    w_err   = 1'b0;
    case (bus.op_code)
      4'd0: begin
        w_data  = w_sum[7:0];
        w_carry = w_sum[8];
      end
      4'd1: begin
        w_data  = bus.a - bus.b;
        w_carry = (bus.a < bus.b);
      end
      4'd2: w_data = bus.a << bus.b[2:0];
      4'd3: w_data = bus.a >> bus.b[2:0];
      4'd4: w_data = bus.a & bus.b;
      4'd5: w_data = bus.a | bus.b;
      4'd6: w_data = bus.a ^ bus.b;
      4'd7: w_data = (bus.a == bus.b) ? 8'h01 : 8'h00;
      default: w_err = 1'b1;
    endcase
    w_result = {w_err, w_carry, w_data};
  end

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake outputs from registered state only, then occupancy next-state
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b1;
    w_rsp_valid  = 1'b0;
    case (r_state)
      StEmpty: begin
        w_req_ready = 1'b1;
        w_rsp_valid = 1'b0;
      end
      StOne: begin
        w_req_ready = 1'b1;
        w_rsp_valid = 1'b1;
      end
      StFull: begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b1;
      end
      default: begin
        w_req_ready = 1'b1;
        w_rsp_valid = 1'b0;
      end
    endcase

    w_push = bus.req_valid & w_req_ready;
    w_pop  = w_rsp_valid & bus.rsp_ready;

    case (r_state)
      StEmpty: if (w_push) w_state_next = StOne;
      StOne: begin
        if (w_push && !w_pop) begin
          w_state_next = StFull;
        end else if (w_pop && !w_push) begin
          w_state_next = StEmpty;
        end
      end
      StFull:  if (w_pop) w_state_next = StOne;
      default: w_state_next = StEmpty;
    endcase
  end

  // FIFO storage and pop counter; the head register always holds the oldest entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head      <= 10'd0;
      r_tail      <= 10'd0;
      r_txn_count <= 8'd0;
    end else begin
      if (w_pop) begin
        r_txn_count <= r_txn_count + 8'd1;
      end
      case (r_state)
        StEmpty: if (w_push) r_head <= w_result;
        StOne: begin
          // Push with pop: new entry replaces the departing head directly
          if (w_push && w_pop) begin
            r_head <= w_result;
          end else if (w_push) begin
            r_tail <= w_result;
          end
        end
        StFull:  if (w_pop) r_head <= r_tail;
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_head[7:0];
  assign bus.rsp_carry = r_head[8];
  assign bus.rsp_err   = r_head[9];
  assign bus.txn_count = r_txn_count;

endmodule

// File: tb/tb_alu_resp.sv
// Self-checking bench for alu_resp: directed cases plus 10,000 random requests
// under random backpressure, checked against a reference model and scoreboard.
module tb_alu_resp;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_resp_if u_if ();

  alu_resp u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [9:0]  sb_q[$];
  logic [7:0]  pop_log[$];
  logic [7:0]  exp_cnt;

  // Reference result packed as {err, carry, data}
  function automatic logic [9:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] d;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        return {1'b0, s[8], s[7:0]};
      end
      4'd1: begin
        d = a - b;
        return {1'b0, (a < b), d};
      end
      4'd2: begin
        d = a << b[2:0];
        return {2'b00, d};
      end
      4'd3: begin
        d = a >> b[2:0];
        return {2'b00, d};
      end
      4'd4: return {2'b00, a & b};
      4'd5: return {2'b00, a | b};
      4'd6: return {2'b00, a ^ b};
      4'd7: return {2'b00, (a == b) ? 8'h01 : 8'h00};
      default: return {1'b1, 1'b0, 8'h00};
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called mid-cycle: check occupancy-visible outputs, log handshakes, advance one cycle
  task automatic tick();
    logic       acc;
    logic       pop;
    logic [9:0] exp;
    check_eq("rsp_valid", u_if.rsp_valid, sb_q.size() > 0);
    check_eq("req_ready", u_if.req_ready, sb_q.size() < 2);
    check_eq("txn_count", u_if.txn_count, exp_cnt);
    acc = u_if.req_valid && u_if.req_ready;
    pop = u_if.rsp_valid && u_if.rsp_ready;
    if (pop) begin
      if (sb_q.size() == 0) begin
        check_eq("pop_with_empty_model", sb_q.size(), 1);
      end else begin
        exp = sb_q.pop_front();
        check_eq("rsp_word", {u_if.rsp_err, u_if.rsp_carry, u_if.rsp_data}, exp);
        pop_log.push_back(u_if.rsp_data);
        exp_cnt++;
      end
    end
    if (acc) sb_q.push_back(alu_model(u_if.op_code, u_if.a, u_if.b));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bit done = 1'b0;
    u_if.req_valid = 1'b1;
    u_if.op_code   = op;
    u_if.a         = a;
    u_if.b         = b;
    for (int i = 0; i < 20 && !done; i++) begin
      done = u_if.req_ready;
      tick();
    end
    u_if.req_valid = 1'b0;
    if (!done) check_eq("send_timeout", done, 1);
  endtask

  task automatic expect_head(input string tag, input logic [7:0] data, input logic carry,
                             input logic err);
    check_eq({tag, "_valid"}, u_if.rsp_valid, 1);
    check_eq({tag, "_data"}, u_if.rsp_data, data);
    check_eq({tag, "_carry"}, u_if.rsp_carry, carry);
    check_eq({tag, "_err"}, u_if.rsp_err, err);
  endtask

  task automatic drain();
    u_if.rsp_ready = 1'b1;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    check_eq("drain_left", sb_q.size(), 0);
  endtask

  // One reset edge with whatever request/response inputs are currently driven
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset          = 1'b0;
    u_if.req_valid = 1'b0;
    u_if.rsp_ready = 1'b0;
    sb_q.delete();
    exp_cnt = 8'd0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_rsp_valid"}, u_if.rsp_valid, 0);
    check_eq({tag, "_req_ready"}, u_if.req_ready, 1);
    check_eq({tag, "_rsp_data"}, u_if.rsp_data, 0);
    check_eq({tag, "_rsp_carry"}, u_if.rsp_carry, 0);
    check_eq({tag, "_rsp_err"}, u_if.rsp_err, 0);
    check_eq({tag, "_txn_count"}, u_if.txn_count, 0);
  endtask

  initial begin
    int unsigned sent;
    logic [8:0]  b_wide;
    reset          = 1'b1;
    u_if.req_valid = 1'b0;
    u_if.rsp_ready = 1'b0;
    u_if.a         = 8'd0;
    u_if.b         = 8'd0;
    u_if.op_code   = 4'd0;
    exp_cnt        = 8'd0;
    @(negedge clk);
    do_reset();
    check_reset("por");

    // ADD with carry out
    u_if.rsp_ready = 1'b1;
    send(4'd0, 8'd200, 8'd100);
    expect_head("add", 8'd44, 1'b1, 1'b0);
    tick();

    // EQ, b truncated from 321 to 65
    b_wide = 9'd321;
    send(4'd7, 8'd104, b_wide[7:0]);
    expect_head("eq_ne", 8'd0, 1'b0, 1'b0);
    tick();
    send(4'd7, 8'd32, 8'd32);
    expect_head("eq_eq", 8'd1, 1'b0, 1'b0);
    tick();

    // SUB borrow, SLL uses only b[2:0]
    send(4'd1, 8'd5, 8'd7);
    expect_head("sub", 8'd254, 1'b1, 1'b0);
    tick();
    send(4'd2, 8'h81, 8'd9);
    expect_head("sll", 8'h02, 1'b0, 1'b0);
    tick();

    // Illegal op then a legal one
    send(4'd9, 8'h12, 8'h34);
    expect_head("illegal", 8'h00, 1'b0, 1'b1);
    tick();
    send(4'd6, 8'h0F, 8'h3C);
    expect_head("xor_after_err", 8'h33, 1'b0, 1'b0);
    tick();

    // Backpressure: fill FIFO, hold third request, then drain in order
    do_reset();
    pop_log.delete();
    send(4'd0, 8'h01, 8'h01);
    send(4'd4, 8'hFF, 8'h0F);
    check_eq("full_req_ready", u_if.req_ready, 0);
    u_if.req_valid = 1'b1;
    u_if.op_code   = 4'd6;
    u_if.a         = 8'hAA;
    u_if.b         = 8'hFF;
    for (int i = 0; i < 3; i++) tick();
    check_eq("held_occupancy", sb_q.size(), 2);
    u_if.rsp_ready = 1'b1;
    send(4'd6, 8'hAA, 8'hFF);
    drain();
    check_eq("order_count", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      check_eq("order_0", pop_log[0], 8'h02);
      check_eq("order_1", pop_log[1], 8'h0F);
      check_eq("order_2", pop_log[2], 8'h55);
    end
    check_eq("bp_txn_count", u_if.txn_count, 3);

    // Reset while FULL, with push and pop requested on the reset edge
    u_if.rsp_ready = 1'b0;
    send(4'd5, 8'h10, 8'h01);
    send(4'd5, 8'h20, 8'h02);
    check_eq("pre_reset_full", u_if.req_ready, 0);
    u_if.rsp_ready = 1'b1;
    u_if.req_valid = 1'b1;
    do_reset();
    check_reset("full_reset");

    // Random traffic with backpressure on both sides
    sent = 0;
    for (int cyc = 0; cyc < 80000 && sent < 10000; cyc++) begin
      if (!u_if.req_valid) begin
        u_if.req_valid = ($urandom_range(3) != 0);
        u_if.op_code   = 4'($urandom_range(15));
        u_if.a         = 8'($urandom_range(255));
        u_if.b         = 8'($urandom_range(255));
      end
      u_if.rsp_ready = ($urandom_range(3) != 0);
      if (u_if.req_valid && u_if.req_ready) begin
        sent++;
        tick();
        u_if.req_valid = 1'b0;
      end else begin
        tick();
      end
    end
    check_eq("rand_sent", sent, 10000);
    u_if.req_valid = 1'b0;
    drain();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
